// File: rtl/quiz_pkg.sv
// Shared types and helpers for the quiz score engine and its buzzer arbiter.
package quiz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  // Ceiling log2, never below 1 so a two-player index is still one bit wide.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/buzz_arbiter.sv
// Rising-edge detector on the player buttons with a lowest-index priority pick.
module buzz_arbiter
  import quiz_pkg::*;
#(
  parameter  int N_PLAYERS = 4,
  localparam int PID_W     = clog2(N_PLAYERS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PLAYERS-1:0] buzz,
  output logic                 hit,
  output logic [PID_W-1:0]     hit_id
);

  logic [N_PLAYERS-1:0] buzz_prev;
  logic [N_PLAYERS-1:0] buzz_edge;

  // History resets to all ones so a button held through reset is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buzz_prev <= '1;
    end else begin
      buzz_prev <= buzz;
    end
  end

  assign buzz_edge = buzz & ~buzz_prev;
  assign hit       = |buzz_edge;

  always_comb begin
    hit_id = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (buzz_edge[i]) hit_id = PID_W'(i);
    end
  end

endmodule

// File: rtl/quiz_score_engine.sv
// N-player buzzer/score controller with saturating scores, answer timeout and leader tracking.
//   state  | meaning
//   IDLE   | waiting for start; buttons and judge ignored
//   ARMED  | round open; first new press locks, else timeout voids the round
//   LOCKED | a player holds the answer right; waiting for a single judge pulse
//   UPDATE | one cycle: write the locked player's score, then back to IDLE
module quiz_score_engine
  import quiz_pkg::*;
#(
  parameter  int N_PLAYERS   = 4,
  parameter  int SCORE_W     = 8,
  parameter  int INIT_SCORE  = 20,
  parameter  int PTS_RIGHT   = 10,
  parameter  int PTS_WRONG   = 5,
  parameter  int TIMEOUT_CYC = 16,
  localparam int PID_W       = clog2(N_PLAYERS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_PLAYERS-1:0]         buzz,
  input  logic                         judge_yes,
  input  logic                         judge_no,
  input  logic                         reload,
  output logic                         lock_valid,
  output logic [PID_W-1:0]             lock_id,
  output logic                         round_void,
  output logic [1:0]                   state,
  output logic [N_PLAYERS*SCORE_W-1:0] scores,
  output logic [PID_W-1:0]             leader_id
);

  localparam int                 TMR_W      = clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [SCORE_W-1:0] SCORE_INIT = SCORE_W'(INIT_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W:0]   RIGHT_EXT  = (SCORE_W + 1)'(PTS_RIGHT);
  localparam logic [SCORE_W-1:0] WRONG_PTS  = SCORE_W'(PTS_WRONG);

  state_t               state_q;
  logic [TMR_W-1:0]     timer_q;
  logic                 lock_valid_q;
  logic [PID_W-1:0]     lock_id_q;
  logic                 round_void_q;
  logic                 op_add_q;
  logic [SCORE_W-1:0]   score_q [N_PLAYERS];
  logic [PID_W-1:0]     leader_q;

  logic                 hit;
  logic [PID_W-1:0]     hit_id;

  logic [SCORE_W-1:0]   cur_score;
  logic [SCORE_W:0]     sum_ext;
  logic [SCORE_W-1:0]   add_score;
  logic [SCORE_W-1:0]   sub_score;
  logic [SCORE_W-1:0]   new_score;
  logic [SCORE_W-1:0]   best_score;
  logic [PID_W-1:0]     best_id;

  buzz_arbiter #(
    .N_PLAYERS (N_PLAYERS)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .buzz   (buzz),
    .hit    (hit),
    .hit_id (hit_id)
  );

  // Extra carry bit catches overflow so the add clamps instead of wrapping.
  always_comb begin
    cur_score = score_q[lock_id_q];
    sum_ext   = {1'b0, cur_score} + RIGHT_EXT;
    add_score = sum_ext[SCORE_W] ? SCORE_MAX : sum_ext[SCORE_W-1:0];
    sub_score = (cur_score < WRONG_PTS) ? '0 : (cur_score - WRONG_PTS);
    new_score = op_add_q ? add_score : sub_score;
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_id    = '0;
    best_score = score_q[0];
    for (int i = 1; i < N_PLAYERS; i++) begin
      if (score_q[i] > best_score) begin
        best_score = score_q[i];
        best_id    = PID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      lock_valid_q <= 1'b0;
      lock_id_q    <= '0;
      round_void_q <= 1'b0;
      op_add_q     <= 1'b0;
    end else begin
      round_void_q <= 1'b0;
      if (reload) begin
        state_q      <= ST_IDLE;
        timer_q      <= '0;
        lock_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q <= ST_ARMED;
              timer_q <= '0;
            end
          end
          ST_ARMED: begin
            if (hit) begin
              lock_id_q    <= hit_id;
              lock_valid_q <= 1'b1;
              state_q      <= ST_LOCKED;
            end else if (timer_q == TMR_LAST) begin
              state_q      <= ST_IDLE;
              round_void_q <= 1'b1;
            end else begin
              timer_q <= timer_q + TMR_W'(1);
            end
          end
          ST_LOCKED: begin
            if (judge_yes ^ judge_no) begin
              op_add_q <= judge_yes;
              state_q  <= ST_UPDATE;
            end
          end
          ST_UPDATE: begin
            lock_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_PLAYERS; i++) score_q[i] <= SCORE_INIT;
      leader_q <= '0;
    end else begin
      leader_q <= best_id;
      if (reload) begin
        for (int i = 0; i < N_PLAYERS; i++) score_q[i] <= SCORE_INIT;
      end else if (state_q == ST_UPDATE) begin
        score_q[lock_id_q] <= new_score;
      end
    end
  end

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_flat
    assign scores[g*SCORE_W +: SCORE_W] = score_q[g];
  end

  assign state      = state_q;
  assign lock_valid = lock_valid_q;
  assign lock_id    = lock_id_q;
  assign round_void = round_void_q;
  assign leader_id  = leader_q;

endmodule

// File: tb/tb_quiz_score_engine.sv
// Bench for quiz_score_engine: directed vector table, hand corner sequences, random vs reference model.
module tb_quiz_score_engine;

  localparam int N     = 4;
  localparam int SW    = 8;
  localparam int INIT  = 20;
  localparam int RIGHT = 10;
  localparam int WRONG = 5;
  localparam int TOUT  = 16;
  localparam int SMAX  = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, judge_yes, judge_no, reload;
  logic [N-1:0]  buzz;
  logic          lock_valid;
  logic [1:0]    lock_id;
  logic          round_void;
  logic [1:0]    state;
  logic [N*SW-1:0] scores;
  logic [1:0]    leader_id;

  quiz_score_engine #(
    .N_PLAYERS(N), .SCORE_W(SW), .INIT_SCORE(INIT),
    .PTS_RIGHT(RIGHT), .PTS_WRONG(WRONG), .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .buzz(buzz),
    .judge_yes(judge_yes), .judge_no(judge_no), .reload(reload),
    .lock_valid(lock_valid), .lock_id(lock_id), .round_void(round_void),
    .state(state), .scores(scores), .leader_id(leader_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int score_of(input int i);
    return int'(scores[i*SW +: SW]);
  endfunction

  task automatic drive(input logic st, input logic [3:0] bz, input logic jy,
                       input logic jn, input logic rl);
    start = st; buzz = bz; judge_yes = jy; judge_no = jn; reload = rl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic st; logic [3:0] bz; logic jy; logic jn; logic rl;
    int e_state; logic e_lv; int e_lid; logic e_rv; int e_pidx; int e_score; int e_leader;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t v(input logic st, input logic [3:0] bz, input logic jy,
                             input logic jn, input logic rl, input int es, input logic elv,
                             input int elid, input logic erv, input int ep, input int esc,
                             input int eld);
    vec_t r;
    r.st = st; r.bz = bz; r.jy = jy; r.jn = jn; r.rl = rl;
    r.e_state = es; r.e_lv = elv; r.e_lid = elid; r.e_rv = erv;
    r.e_pidx = ep; r.e_score = esc; r.e_leader = eld;
    return r;
  endfunction

  // Reference model: round bookkeeping in plain integers.
  int mst, mlid, mleader, melapsed;
  int mscore[N];
  bit mlv, mrv, madd;
  logic [N-1:0] mprev;

  task automatic model_reset();
    mst = 0; mlid = 0; mleader = 0; melapsed = 0;
    mlv = 0; mrv = 0; madd = 0; mprev = '1;
    for (int i = 0; i < N; i++) mscore[i] = INIT;
  endtask

  task automatic model_step(input logic st, input logic [N-1:0] bz, input logic jy,
                            input logic jn, input logic rl);
    int best;
    int lead;
    bit void_now;
    logic [N-1:0] edges;
    lead = 0; best = mscore[0];
    for (int i = 1; i < N; i++) if (mscore[i] > best) begin best = mscore[i]; lead = i; end
    edges = bz & ~mprev;
    void_now = 0;
    if (rl) begin
      for (int i = 0; i < N; i++) mscore[i] = INIT;
      mst = 0; mlv = 0; melapsed = 0;
    end else if (mst == 0) begin
      if (st) begin mst = 1; melapsed = 0; end
    end else if (mst == 1) begin
      if (edges != 0) begin
        for (int i = N - 1; i >= 0; i--) if (edges[i]) mlid = i;
        mlv = 1; mst = 2;
      end else begin
        melapsed++;
        if (melapsed >= TOUT) begin mst = 0; void_now = 1; end
      end
    end else if (mst == 2) begin
      if (jy != jn) begin madd = jy; mst = 3; end
    end else begin
      if (madd) mscore[mlid] = (mscore[mlid] + RIGHT > SMAX) ? SMAX : mscore[mlid] + RIGHT;
      else      mscore[mlid] = (mscore[mlid] < WRONG) ? 0 : mscore[mlid] - WRONG;
      mlv = 0; mst = 0;
    end
    mrv = void_now;
    mleader = lead;
    mprev = bz;
  endtask

  task automatic play_round(input int p, input bit yes);
    drive(1, 4'b0000, 0, 0, 0); tick();
    drive(0, 4'(1 << p), 0, 0, 0); tick();
    chk("round_lock_valid", int'(lock_valid), 1);
    chk("round_lock_id", int'(lock_id), p);
    drive(0, 4'b0000, yes, !yes, 0); tick();
    drive(0, 4'b0000, 0, 0, 0); tick(); tick();
  endtask

  initial begin
    int n;
    int exp;
    logic st_r, jy_r, jn_r, rl_r;
    logic [N-1:0] bz_r;

    vecs[0]  = v(1, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 2, 20, 0);
    vecs[1]  = v(0, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 2, 20, 0);
    vecs[2]  = v(0, 4'b0100, 0, 0, 0, 2, 1, 2, 0, 2, 20, 0);
    vecs[3]  = v(0, 4'b0100, 0, 0, 0, 2, 1, 2, 0, 2, 20, 0);
    vecs[4]  = v(0, 4'b0000, 1, 0, 0, 3, 1, 2, 0, 2, 20, 0);
    vecs[5]  = v(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 2, 30, 0);
    vecs[6]  = v(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 2, 30, 2);
    vecs[7]  = v(1, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 1, 20, 2);
    vecs[8]  = v(0, 4'b1010, 0, 0, 0, 2, 1, 1, 0, 1, 20, 2);
    vecs[9]  = v(0, 4'b0000, 0, 1, 0, 3, 1, 1, 0, 1, 20, 2);
    vecs[10] = v(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1, 15, 2);
    vecs[11] = v(1, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 0, 20, 2);
    vecs[12] = v(0, 4'b0001, 0, 0, 0, 2, 1, 0, 0, 0, 20, 2);
    vecs[13] = v(0, 4'b0001, 1, 1, 0, 2, 1, 0, 0, 0, 20, 2);
    vecs[14] = v(0, 4'b0000, 0, 0, 0, 2, 1, 0, 0, 0, 20, 2);
    vecs[15] = v(0, 4'b0000, 1, 0, 0, 3, 1, 0, 0, 0, 20, 2);
    vecs[16] = v(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 30, 2);
    vecs[17] = v(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 30, 0);
    vecs[18] = v(1, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 0, 30, 0);
    vecs[19] = v(0, 4'b1000, 0, 0, 0, 2, 1, 3, 0, 0, 30, 0);
    vecs[20] = v(0, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0, 20, 0);
    vecs[21] = v(1, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 2, 20, 0);
    vecs[22] = v(0, 4'b0000, 1, 0, 0, 0, 0, 0, 0, 1, 20, 0);

    rst = 1'b0;
    drive(0, 4'b0000, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", int'(state), 0);
    chk("reset_lock_valid", int'(lock_valid), 0);
    chk("reset_lock_id", int'(lock_id), 0);
    chk("reset_round_void", int'(round_void), 0);
    chk("reset_leader", int'(leader_id), 0);
    for (int i = 0; i < N; i++) chk("reset_score", score_of(i), INIT);
    rst = 1'b1;

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].st, vecs[i].bz, vecs[i].jy, vecs[i].jn, vecs[i].rl);
      tick();
      chk($sformatf("vec%0d_state", i), int'(state), vecs[i].e_state);
      chk($sformatf("vec%0d_lock_valid", i), int'(lock_valid), int'(vecs[i].e_lv));
      if (vecs[i].e_lv) chk($sformatf("vec%0d_lock_id", i), int'(lock_id), vecs[i].e_lid);
      chk($sformatf("vec%0d_round_void", i), int'(round_void), int'(vecs[i].e_rv));
      chk($sformatf("vec%0d_score", i), score_of(vecs[i].e_pidx), vecs[i].e_score);
      chk($sformatf("vec%0d_leader", i), int'(leader_id), vecs[i].e_leader);
    end

    // Floor at zero for player 1, then saturation at the top for player 0.
    for (int k = 1; k <= 5; k++) begin
      play_round(1, 0);
      exp = INIT - WRONG * k;
      if (exp < 0) exp = 0;
      chk($sformatf("floor_round%0d", k), score_of(1), exp);
    end
    for (int k = 1; k <= 24; k++) begin
      play_round(0, 1);
      exp = INIT + RIGHT * k;
      if (exp > SMAX) exp = SMAX;
      chk($sformatf("sat_round%0d", k), score_of(0), exp);
    end
    chk("sat_leader", int'(leader_id), 0);

    // Button held before the round opens never wins; round voids after the window.
    drive(0, 4'b1000, 0, 0, 0); tick();
    drive(1, 4'b1000, 0, 0, 0); tick();
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      drive(0, 4'b1000, 0, 0, 0); tick();
      n = c;
      if (round_void) break;
    end
    chk("timeout_cycles", n, TOUT);
    chk("timeout_state", int'(state), 0);
    chk("timeout_lock_valid", int'(lock_valid), 0);
    drive(0, 4'b1000, 0, 0, 0); tick();
    chk("timeout_pulse_width", int'(round_void), 0);
    chk("timeout_score0", score_of(0), 255);
    chk("timeout_score1", score_of(1), 0);
    chk("timeout_score3", score_of(3), 20);
    drive(0, 4'b0000, 0, 0, 0); tick();
    drive(1, 4'b0000, 0, 0, 0); tick();
    drive(0, 4'b1000, 0, 0, 0); tick();
    chk("repress_lock_id", int'(lock_id), 3);
    chk("repress_lock_valid", int'(lock_valid), 1);
    drive(0, 4'b0000, 1, 0, 0); tick();
    drive(0, 4'b0000, 0, 0, 0); tick(); tick();
    chk("repress_score3", score_of(3), 30);

    // Edge arriving on the final cycle of the window beats the timeout.
    drive(1, 4'b0000, 0, 0, 0); tick();
    repeat (TOUT - 1) begin drive(0, 4'b0000, 0, 0, 0); tick(); end
    drive(0, 4'b0100, 0, 0, 0); tick();
    chk("lastcycle_state", int'(state), 2);
    chk("lastcycle_lock_id", int'(lock_id), 2);
    chk("lastcycle_round_void", int'(round_void), 0);
    drive(0, 4'b0000, 0, 1, 0); tick();
    drive(0, 4'b0000, 0, 0, 0); tick(); tick();
    chk("lastcycle_score2", score_of(2), 15);

    // Asynchronous reset mid-ARMED acts without a clock edge.
    drive(1, 4'b0000, 0, 0, 0); tick();
    drive(0, 4'b0000, 0, 0, 0); tick();
    #3 rst = 1'b0;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_score0", score_of(0), INIT);
    chk("async_score3", score_of(3), INIT);
    chk("async_lock_valid", int'(lock_valid), 0);
    chk("async_leader", int'(leader_id), 0);
    #2 rst = 1'b1;
    model_reset();

    for (int c = 0; c < 3000; c++) begin
      st_r = ($urandom_range(0, 3) == 0);
      bz_r = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : buzz;
      jy_r = ($urandom_range(0, 2) == 0);
      jn_r = ($urandom_range(0, 2) == 0);
      rl_r = ($urandom_range(0, 99) == 0);
      drive(st_r, bz_r, jy_r, jn_r, rl_r);
      @(posedge clk);
      model_step(st_r, bz_r, jy_r, jn_r, rl_r);
      #1;
      chk("rand_state", int'(state), mst);
      chk("rand_lock_valid", int'(lock_valid), int'(mlv));
      if (mlv) chk("rand_lock_id", int'(lock_id), mlid);
      chk("rand_round_void", int'(round_void), int'(mrv));
      chk("rand_leader", int'(leader_id), mleader);
      for (int i = 0; i < N; i++) chk($sformatf("rand_score%0d", i), score_of(i), mscore[i]);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/quiz_score_engine.md
Name: quiz_score_engine

Overview:
- Parametrised successor to the two-player answer/score controller.
- Generalises to N players with a first-press buzzer lock and configurable reward/penalty.
- Adds saturating score arithmetic, an answer-window timeout and leader tracking.
- Sits between the debounced player/judge inputs and the display driver. Outputs are raw scores and status; segment encoding stays in the display block.

Parameters:
- N_PLAYERS, 4, number of players (2..8)
- SCORE_W, 8, score width per player, unsigned
- INIT_SCORE, 20, score loaded on reset and reload
- PTS_RIGHT, 10, points added on a correct judgement
- PTS_WRONG, 5, points subtracted on a wrong judgement
- TIMEOUT_CYC, 16, ARMED-state cycles before the round is voided

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; opens a round
- buzz  in  N_PLAYERS  player buttons, synchronised and debounced, level
- judge_yes  in  1  one-cycle pulse; the locked answer is correct
- judge_no  in  1  one-cycle pulse; the locked answer is wrong
- reload  in  1  one-cycle pulse; restores all scores to INIT_SCORE
- lock_valid  out  1  a player holds the answer right
- lock_id  out  clog2(N_PLAYERS)  index of the locked player
- round_void  out  1  one-cycle pulse on timeout
- state  out  2  FSM state encoding
- scores  out  N_PLAYERS*SCORE_W  flat; player i occupies [i*SCORE_W +: SCORE_W]
- leader_id  out  clog2(N_PLAYERS)  index of the highest score

Behaviour:
- Reset (rst=0, async): state=IDLE, every score=INIT_SCORE, lock_valid=0, lock_id=0, round_void=0, leader_id=0, timer=0, buzz history=all ones.
- FSM states: IDLE=0, ARMED=1, LOCKED=2, UPDATE=3.
- IDLE:
  - start -> ARMED next cycle; timer cleared.
  - buzz, judge_yes and judge_no are ignored.
- ARMED:
  - Buzz edge = buzz & ~buzz_prev. Buttons already held when the round opens never win.
  - Any edge -> LOCKED next cycle. lock_id = lowest-index edge; lock_valid=1.
  - Simultaneous edges resolve to the lowest index.
  - With no edge, timer increments each cycle. Once TIMEOUT_CYC cycles have elapsed -> IDLE and round_void=1 for one cycle.
  - An edge on the timeout cycle wins over the timeout.
  - start in ARMED is ignored.
- LOCKED:
  - judge_yes alone -> UPDATE with an add.
  - judge_no alone -> UPDATE with a subtract.
  - Both asserted together is ignored; stay in LOCKED.
  - No timeout in this state; further buzzes are ignored.
- UPDATE (one cycle):
  - Score of lock_id is written.
  - Add: min(score+PTS_RIGHT, 2^SCORE_W-1), computed at SCORE_W+1 bits.
  - Subtract: score<PTS_WRONG ? 0 : score-PTS_WRONG.
  - lock_valid clears, then -> IDLE.
  - Score latency: judge pulse in cycle t -> new score visible in cycle t+2.
- reload:
  - Highest priority among synchronous events, in any state.
  - All scores=INIT_SCORE, state=IDLE, lock_valid=0, timer=0, and no score write happens that cycle.
  - reload together with start: reload wins and start is dropped.
- leader_id:
  - Registered argmax of scores; lowest index wins ties.
  - Updates one cycle after any score change, i.e. t+3 from the judge pulse.
- buzz_prev is updated every cycle in all states.

Decomposition:
- Shared package quiz_pkg:
  - state enum (IDLE/ARMED/LOCKED/UPDATE)
  - function clog2
  - PID_W = clog2(N_PLAYERS) expressed as a localparam pattern
- Sub-module buzz_arbiter:
  - buzz_prev register, edge detection and lowest-index fixed-priority encoder.
  - Outputs hit and hit_id.
  - Instantiated once.
- Score registers, saturation logic and leader comparator stay in the top module.

Test Plan (N=4, SCORE_W=8, INIT=20, RIGHT=10, WRONG=5, TIMEOUT=16):
- Reset then start; buzz[2] rises at cycle 3 -> lock_id=2, lock_valid=1; judge_yes -> score2=30 two cycles later, leader_id=2 one cycle after that, state=IDLE.
- start; buzz=4'b1010 rises in a single cycle -> lock_id=1; judge_no -> score1=15; four further wrong rounds for player 1 -> scores 10, 5, 0, 0 (floor holds at 0).
- Player 0 correct 24 times from 20 -> 250, then 255 saturated (never wraps); leader_id=0.
- start with buzz[3] held high beforehand and no new edge -> after 16 cycles round_void pulses once, state=IDLE, scores unchanged; buzz[3] released and re-pressed in the next round -> locks 3.
- In LOCKED, judge_yes and judge_no asserted together -> no state or score change; a later judge_yes alone is accepted.
- reload during LOCKED and again coincident with start -> all scores=20, state=IDLE, lock_valid=0; async rst pulsed mid-ARMED -> immediate reset values without waiting for a clock edge.
